// File: rtl/truth_table_sequencer_pkg.sv
// Shared types for the truth-table sequencer: FSM state encoding,
// default golden table and small decode helpers.
package truth_table_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } tts_state_e;

    // Default golden table: identity mapping for the 3-in/3-out block,
    // entry i lives at bits [i*3 +: 3].
    localparam int unsigned DEF_N_IN     = 3;
    localparam int unsigned DEF_N_OUT    = 3;
    localparam logic [23:0] DEF_EXPECTED = 24'hFAC688;

    // Width of the settle down-counter; a zero settle time still needs one bit.
    function automatic int unsigned settle_width(input int unsigned settle_cyc);
        return (settle_cyc > 0) ? $clog2(settle_cyc + 1) : 1;
    endfunction

    // The vector sequence is active in DRIVE, WAIT and CHECK only.
    function automatic logic is_busy(input tts_state_e st);
        return (st == ST_DRIVE) || (st == ST_WAIT) || (st == ST_CHECK);
    endfunction

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Loadable down-counter that times the settle interval between driving a
// vector and sampling the response.
module settle_timer #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load on request, otherwise count down and rest at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Final settle cycle is the one where the count sits at 1.
    assign expired = (cnt_q == W'(1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Exhaustive truth-table sequencer: steps every input vector onto an
// external combinational block, waits a settle time, compares the response
// against a packed golden table and reports pass/error count/first failure.
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int unsigned N_IN       = 3,
    parameter int unsigned N_OUT      = 3,
    parameter int unsigned SETTLE_CYC = 1,
    parameter logic [(2**N_IN)*N_OUT-1:0] EXPECTED = 24'hFAC688
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  dut_in,
    input  logic [N_OUT-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic             fail_valid,
    output logic [N_IN-1:0]  first_fail_idx
);

    localparam int unsigned TW = settle_width(SETTLE_CYC);

    tts_state_e        state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [N_IN-1:0]   dut_in_q, dut_in_d;
    logic [N_IN:0]     err_q, err_d;
    logic              fv_q, fv_d;
    logic [N_IN-1:0]   ff_q, ff_d;
    logic              pass_q, pass_d;
    logic              tmr_load;
    logic              tmr_expired;
    logic [N_OUT-1:0]  exp_tbl [2**N_IN];

    // Unpack the golden table once so lookup is a plain array index.
    for (genvar g = 0; g < 2**N_IN; g++) begin : g_tbl
        assign exp_tbl[g] = EXPECTED[g*N_OUT +: N_OUT];
    end

    settle_timer #(
        .W (TW)
    ) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (TW'(SETTLE_CYC)),
        .expired  (tmr_expired)
    );

    // Next-state and datapath updates; abort pre-empts any CHECK update.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dut_in_d = dut_in_q;
        err_d    = err_q;
        fv_d     = fv_q;
        ff_d     = ff_q;
        pass_d   = pass_q;
        tmr_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    idx_d   = '0;
                    err_d   = '0;
                    fv_d    = 1'b0;
                    ff_d    = '0;
                    pass_d  = 1'b0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    dut_in_d = idx_q;
                    tmr_load = 1'b1;
                    state_d  = (SETTLE_CYC > 0) ? ST_WAIT : ST_CHECK;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (tmr_expired) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    pass_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    if (dut_out != exp_tbl[idx_q]) begin
                        err_d = err_q + (N_IN+1)'(1);
                        if (!fv_q) begin
                            fv_d = 1'b1;
                            ff_d = idx_q;
                        end
                    end
                    // pass is resolved here so it is already valid while done is high
                    if (idx_q == '1) begin
                        pass_d  = (err_d == '0);
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + N_IN'(1);
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            dut_in_q <= '0;
            err_q    <= '0;
            fv_q     <= 1'b0;
            ff_q     <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            dut_in_q <= dut_in_d;
            err_q    <= err_d;
            fv_q     <= fv_d;
            ff_q     <= ff_d;
            pass_q   <= pass_d;
        end
    end

    assign dut_in         = dut_in_q;
    assign busy           = is_busy(state_q);
    assign done           = (state_q == ST_DONE);
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign fail_valid     = fv_q;
    assign first_fail_idx = ff_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: three builds (settle 1, 0, 3),
// loopback and stuck-at-D circuit models, abort, reset and re-trigger cases.
module tb_truth_table_sequencer;
    import truth_table_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic abort = 1'b0;
    logic stuck = 1'b0;
    logic start_r [3];
    logic [2:0] din_w [3];
    logic [2:0] dout0, dout1, dout2;
    logic busy_w [3];
    logic done_w [3];
    logic pass_w [3];
    logic [3:0] err_w [3];
    logic fv_w [3];
    logic [2:0] ff_w [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Circuit models: instance 0 is loopback or stuck-at-0 on D, others loopback.
    assign dout0 = stuck ? {1'b0, din_w[0][1:0]} : din_w[0];
    assign dout1 = din_w[1];
    assign dout2 = din_w[2];

    truth_table_sequencer #(.N_IN(3), .N_OUT(3), .SETTLE_CYC(1), .EXPECTED(DEF_EXPECTED)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start_r[0]), .abort(abort),
        .dut_in(din_w[0]), .dut_out(dout0), .busy(busy_w[0]), .done(done_w[0]),
        .pass(pass_w[0]), .err_count(err_w[0]), .fail_valid(fv_w[0]), .first_fail_idx(ff_w[0]));

    truth_table_sequencer #(.N_IN(3), .N_OUT(3), .SETTLE_CYC(0), .EXPECTED(DEF_EXPECTED)) u_s0 (
        .clk(clk), .rst_n(rst_n), .start(start_r[1]), .abort(abort),
        .dut_in(din_w[1]), .dut_out(dout1), .busy(busy_w[1]), .done(done_w[1]),
        .pass(pass_w[1]), .err_count(err_w[1]), .fail_valid(fv_w[1]), .first_fail_idx(ff_w[1]));

    truth_table_sequencer #(.N_IN(3), .N_OUT(3), .SETTLE_CYC(3), .EXPECTED(DEF_EXPECTED)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start_r[2]), .abort(abort),
        .dut_in(din_w[2]), .dut_out(dout2), .busy(busy_w[2]), .done(done_w[2]),
        .pass(pass_w[2]), .err_count(err_w[2]), .fail_valid(fv_w[2]), .first_fail_idx(ff_w[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full run on instance d, sampled on every falling edge after the
    // edge that takes start; k counts rising edges from that edge.
    task automatic run(input int d, input int spc, input int e_err, input int e_ff,
                       input int e_fv, input int e_pass);
        int total;
        int ndone;
        total = 8 * (spc + 2);
        ndone = 0;
        start_r[d] = 1'b1;
        for (int k = 0; k <= total + 2; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start_r[d] = 1'b0;
                chk("pass_cleared", 32'(pass_w[d]), 32'd0);
                chk("err_cleared", 32'(err_w[d]), 32'd0);
            end
            chk("busy", 32'(busy_w[d]), 32'(k < total));
            chk("done", 32'(done_w[d]), 32'(k == total));
            if (k >= 1 && k <= total) chk("dut_in", 32'(din_w[d]), 32'((k - 1) / (spc + 2)));
            if (done_w[d]) ndone++;
            if (k == total) begin
                chk("pass", 32'(pass_w[d]), 32'(e_pass));
                chk("err_count", 32'(err_w[d]), 32'(e_err));
                chk("fail_valid", 32'(fv_w[d]), 32'(e_fv));
                chk("first_fail_idx", 32'(ff_w[d]), 32'(e_ff));
            end
        end
        chk("done_pulses", 32'(ndone), 32'd1);
        chk("pass_held", 32'(pass_w[d]), 32'(e_pass));
    endtask

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "bench time limit exceeded");
    end

    initial begin
        int ndone;
        for (int i = 0; i < 3; i++) start_r[i] = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_dut_in", 32'(din_w[0]), 32'd0);
        chk("rst_busy", 32'(busy_w[0]), 32'd0);
        chk("rst_done", 32'(done_w[0]), 32'd0);
        chk("rst_pass", 32'(pass_w[0]), 32'd0);
        chk("rst_err", 32'(err_w[0]), 32'd0);
        chk("rst_fv", 32'(fv_w[0]), 32'd0);
        chk("rst_ff", 32'(ff_w[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: loopback, default table, done 24 edges after start
        run(0, 1, 0, 0, 0, 1);

        // 2: bit D stuck at 0 -> vectors 4..7 fail
        stuck = 1'b1;
        @(negedge clk);
        run(0, 1, 4, 4, 1, 0);

        // 3: settle 0 and settle 3 builds
        run(1, 0, 0, 0, 0, 1);
        run(2, 3, 0, 0, 0, 1);

        // 4: abort while idx=5 is in WAIT (after edge 16), stuck model
        start_r[0] = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            start_r[0] = 1'b0;
        end
        chk("abort_pre_dut_in", 32'(din_w[0]), 32'd5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy_w[0]), 32'd0);
        chk("abort_done", 32'(done_w[0]), 32'd0);
        chk("abort_pass", 32'(pass_w[0]), 32'd0);
        chk("abort_err", 32'(err_w[0]), 32'd1);
        chk("abort_ff", 32'(ff_w[0]), 32'd4);
        chk("abort_fv", 32'(fv_w[0]), 32'd1);
        ndone = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_w[0] || busy_w[0]) ndone++;
        end
        chk("abort_stays_idle", 32'(ndone), 32'd0);

        // abort and start together in IDLE: no run
        start_r[0] = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start_r[0] = 1'b0;
        abort = 1'b0;
        chk("abort_start_busy", 32'(busy_w[0]), 32'd0);
        @(negedge clk);
        chk("abort_start_busy2", 32'(busy_w[0]), 32'd0);

        // 5: reset during idx=2, then a clean loopback run
        stuck = 1'b0;
        start_r[0] = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            @(negedge clk);
            start_r[0] = 1'b0;
        end
        chk("pre_rst_dut_in", 32'(din_w[0]), 32'd2);
        chk("pre_rst_busy", 32'(busy_w[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dut_in", 32'(din_w[0]), 32'd0);
        chk("mid_rst_busy", 32'(busy_w[0]), 32'd0);
        chk("mid_rst_done", 32'(done_w[0]), 32'd0);
        chk("mid_rst_pass", 32'(pass_w[0]), 32'd0);
        chk("mid_rst_err", 32'(err_w[0]), 32'd0);
        chk("mid_rst_fv", 32'(fv_w[0]), 32'd0);
        chk("mid_rst_ff", 32'(ff_w[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(0, 1, 0, 0, 0, 1);

        // 6: start held high; 26-edge period (24 busy, DONE, one IDLE)
        ndone = 0;
        start_r[0] = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (k == 59) start_r[0] = 1'b0;
            chk("hold_busy", 32'(busy_w[0]), 32'((k < 78) && ((k % 26) < 24)));
            chk("hold_done", 32'(done_w[0]), 32'((k < 78) && ((k % 26) == 24)));
            if (done_w[0]) ndone++;
        end
        chk("hold_done_count", 32'(ndone), 32'd3);
        chk("hold_pass", 32'(pass_w[0]), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
Exhaustive truth-table sequencer for a small combinational block such as simple_circuit3, with 3 inputs and 3 outputs.
On start, it drives every input combination 0..2^N_IN-1 onto the block and waits a programmable settle time.
It then samples the block's outputs and compares them against a packed expected table.
It reports pass/fail, the error count and the first failing vector, so the circuit can be self-checked in hardware rather than by eye in a waveform.

Parameters:
N_IN, 3, width of the driven input vector (A,B,C order = MSB..LSB)
N_OUT, 3, width of the sampled output vector (D,E,F order = MSB..LSB)
SETTLE_CYC, 1, wait cycles between driving a vector and sampling; 0 allowed
EXPECTED, 24'hFAC688, packed golden table; the expected output for vector i is EXPECTED[i*N_OUT +: N_OUT]; width (2**N_IN)*N_OUT

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  level-sampled request to run; honoured only in IDLE
abort  input  1  synchronous cancel of a run in progress
dut_in  output  N_IN  vector driven to the circuit under test
dut_out  input  N_OUT  response from the circuit under test
busy  output  1  high from the first DRIVE through the last CHECK
done  output  1  one-cycle pulse when the run completes (not on abort)
pass  output  1  run result; valid from done until the next accepted start
err_count  output  N_IN+1  number of mismatching vectors, 0..2^N_IN
fail_valid  output  1  at least one mismatch has been captured this run
first_fail_idx  output  N_IN  index of the first mismatching vector

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail_idx=0, idx=0, settle counter=0.
- IDLE:
  - start=1 at an edge: idx<=0; err_count, fail_valid, first_fail_idx and pass cleared; go to DRIVE.
- DRIVE (1 cycle):
  - dut_in<=idx; settle counter<=SETTLE_CYC.
  - Next state is WAIT if SETTLE_CYC>0, else CHECK.
- WAIT:
  - Decrement the counter each cycle.
  - Go to CHECK on the cycle the counter reaches 1. WAIT lasts exactly SETTLE_CYC cycles.
- CHECK (1 cycle):
  - Compare dut_out with EXPECTED[idx*N_OUT +: N_OUT].
  - On mismatch: err_count++. If fail_valid=0, set first_fail_idx<=idx and fail_valid<=1.
  - If idx==2^N_IN-1, go to DONE. Otherwise idx++ and go to DRIVE.
- DONE (1 cycle):
  - done=1; pass<=(err_count==0), including the final CHECK's update.
  - Return to IDLE.
- Per-vector cost is SETTLE_CYC+2 cycles.
  - done is high in the cycle following edge number 2^N_IN*(SETTLE_CYC+2) after the edge that sampled start.
  - With the defaults, done is seen 24 edges after start.
- dut_in is stable through DRIVE→WAIT→CHECK of each vector. It holds the last applied vector in DONE/IDLE.
- busy=1 in DRIVE/WAIT/CHECK; busy=0 in IDLE/DONE.
- start while not in IDLE is ignored. start held high continuously re-triggers from IDLE after each DONE.
- abort in DRIVE/WAIT/CHECK:
  - Go to IDLE next edge; no done; pass<=0.
  - err_count and first_fail_idx keep their partial values.
  - abort has priority over a same-cycle CHECK update, so that vector is not counted.
- abort in IDLE/DONE has no effect. abort and start together in IDLE: abort wins and the run does not start.
- rst_n low mid-run returns all state and outputs to reset values immediately. No done.
- err_count saturation is impossible, since its width is N_IN+1.
- idx width is N_IN and is compared, never wrapped.

Decomposition:
- Shared package/include: state encoding localparams (IDLE, DRIVE, WAIT, CHECK, DONE; 3 bits) and the EXPECTED packing macro/function used by both RTL and bench.
- One sub-module, settle_timer: loadable down-counter with clk, rst_n, load, load_val and expired. Width is $clog2(SETTLE_CYC+1), minimum 1.

Test Plan:
1. Loopback model (dut_out=dut_in), default EXPECTED=24'hFAC688, pulse start:
   - dut_in steps 0..7, 3 cycles each; done pulses once 24 edges after start.
   - pass=1, err_count=0, fail_valid=0.
2. Model with bit D stuck at 0 (dut_out={1'b0,dut_in[1:0]}), same EXPECTED:
   - err_count=4, first_fail_idx=4, fail_valid=1, pass=0 at done.
3. SETTLE_CYC=0 and SETTLE_CYC=3 builds, loopback:
   - done arrives 16 and 40 edges after start respectively.
   - dut_in is never sampled in its first cycle.
4. Assert abort while idx=5 in WAIT, with the stuck-D model:
   - IDLE next edge, no done, pass=0, busy=0, err_count=1, first_fail_idx=4.
5. rst_n low for 1 cycle during idx=2, then start again:
   - All outputs are 0 during reset.
   - The new run completes normally with pass=1.
6. start held high for 60 cycles, loopback model:
   - Back-to-back runs with one IDLE cycle between done and the next DRIVE.
   - start pulses during busy are ignored and the run length is unchanged.
